// File: rtl/pipeline_hazard_controller.sv
// Hazard scheduler: operand forwarding selects plus
// stall / multiply-hold / branch-flush sequencing.
module pipeline_hazard_controller #(
  parameter int MUL_CYCLES   = 4,
  parameter int FLUSH_CYCLES = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [3:0]  id_rn,
  input  logic [3:0]  id_rm,
  input  logic        id_rn_used,
  input  logic        id_rm_used,
  input  logic [3:0]  ex_rd,
  input  logic        ex_wr_en,
  input  logic        ex_is_load,
  input  logic [3:0]  mem_rd,
  input  logic        mem_wr_en,
  input  logic [3:0]  wb_rd,
  input  logic        wb_wr_en,
  input  logic        branch_taken,
  input  logic        mul_start,
  output logic [1:0]  fwd_sel_a,
  output logic [1:0]  fwd_sel_b,
  output logic        pc_en,
  output logic        if_id_en,
  output logic        if_id_flush,
  output logic        id_ex_bubble,
  output logic        ex_hold,
  output logic [15:0] perf_stall_cnt
);

  localparam int CW = $clog2(MUL_CYCLES + FLUSH_CYCLES);

  typedef enum logic [1:0] {
    RUN,
    MUL_BUSY,
    FLUSH
  } state_t;

  state_t        state;
  state_t        state_d;
  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_d;

  logic a_ok, b_ok;
  logic a_ex, a_mem, a_wb;
  logic b_ex, b_mem, b_wb;
  logic load_use;

  // Per-stage match detection; PC reads never match anything
  always_comb begin
    a_ok  = id_rn_used && (id_rn != 4'd15);
    b_ok  = id_rm_used && (id_rm != 4'd15);
    a_ex  = a_ok && ex_wr_en  && (ex_rd  == id_rn);
    a_mem = a_ok && mem_wr_en && (mem_rd == id_rn);
    a_wb  = a_ok && wb_wr_en  && (wb_rd  == id_rn);
    b_ex  = b_ok && ex_wr_en  && (ex_rd  == id_rm);
    b_mem = b_ok && mem_wr_en && (mem_rd == id_rm);
    b_wb  = b_ok && wb_wr_en  && (wb_rd  == id_rm);
    load_use = ex_is_load && (a_ex || b_ex);
  end

  // Nearest stage wins; an EX load result is not yet available
  always_comb begin
    fwd_sel_a = 2'b00;
    fwd_sel_b = 2'b00;
    if (!rst) begin
      if (a_ex)       fwd_sel_a = ex_is_load ? 2'b00 : 2'b01;
      else if (a_mem) fwd_sel_a = 2'b10;
      else if (a_wb)  fwd_sel_a = 2'b11;
      if (b_ex)       fwd_sel_b = ex_is_load ? 2'b00 : 2'b01;
      else if (b_mem) fwd_sel_b = 2'b10;
      else if (b_wb)  fwd_sel_b = 2'b11;
    end
  end

  // Next state and front-end enables
  always_comb begin
    state_d      = state;
    cnt_d        = cnt;
    pc_en        = 1'b1;
    if_id_en     = 1'b1;
    if_id_flush  = 1'b0;
    id_ex_bubble = 1'b0;
    ex_hold      = 1'b0;
    case (state)
      RUN: begin
        if (branch_taken) begin
          if_id_flush  = 1'b1;
          id_ex_bubble = 1'b1;
          if (FLUSH_CYCLES > 1) begin
            state_d = FLUSH;
            cnt_d   = CW'(FLUSH_CYCLES - 2);
          end
        end else if (mul_start) begin
          pc_en    = 1'b0;
          if_id_en = 1'b0;
          ex_hold  = 1'b1;
          state_d  = MUL_BUSY;
          cnt_d    = CW'(MUL_CYCLES - 2);
        end else if (load_use) begin
          pc_en        = 1'b0;
          if_id_en     = 1'b0;
          id_ex_bubble = 1'b1;
        end
      end
      MUL_BUSY: begin
        if (cnt != '0) begin
          pc_en    = 1'b0;
          if_id_en = 1'b0;
          ex_hold  = 1'b1;
          cnt_d    = cnt - CW'(1);
        end else begin
          state_d = RUN;
        end
      end
      FLUSH: begin
        if_id_flush  = 1'b1;
        id_ex_bubble = 1'b1;
        if (cnt == '0) state_d = RUN;
        else           cnt_d   = cnt - CW'(1);
      end
      default: state_d = RUN;
    endcase
    if (rst) begin
      state_d      = RUN;
      cnt_d        = '0;
      pc_en        = 1'b1;
      if_id_en     = 1'b1;
      if_id_flush  = 1'b0;
      id_ex_bubble = 1'b0;
      ex_hold      = 1'b0;
    end
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= RUN;
      cnt   <= '0;
    end else begin
      state <= state_d;
      cnt   <= cnt_d;
    end
  end

  // Saturating count of cycles with the PC frozen
  always_ff @(posedge clk) begin
    if (rst)
      perf_stall_cnt <= '0;
    else if (!pc_en && (perf_stall_cnt != 16'hFFFF))
      perf_stall_cnt <= perf_stall_cnt + 16'd1;
  end

endmodule

// File: tb/tb_pipeline_hazard_controller.sv
// Bench: two instances (FLUSH_CYCLES 1 and 2) against a
// cycle-count reference model, directed plus random.
module tb_pipeline_hazard_controller;

  localparam int MULC = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] id_rn, id_rm, ex_rd, mem_rd, wb_rd;
  logic       id_rn_used, id_rm_used;
  logic       ex_wr_en, ex_is_load, mem_wr_en, wb_wr_en;
  logic       branch_taken, mul_start;

  logic [1:0]  sa [2];
  logic [1:0]  sb [2];
  logic        pe [2];
  logic        ie [2];
  logic        fl [2];
  logic        bu [2];
  logic        ho [2];
  logic [15:0] pc [2];

  int total = 0;
  int bad   = 0;

  int busy [2];
  int flc  [2];
  int perf [2];

  always #5 clk = ~clk;

  pipeline_hazard_controller #(.MUL_CYCLES(MULC), .FLUSH_CYCLES(1)) dut0 (
    .clk(clk), .rst(rst),
    .id_rn(id_rn), .id_rm(id_rm),
    .id_rn_used(id_rn_used), .id_rm_used(id_rm_used),
    .ex_rd(ex_rd), .ex_wr_en(ex_wr_en), .ex_is_load(ex_is_load),
    .mem_rd(mem_rd), .mem_wr_en(mem_wr_en),
    .wb_rd(wb_rd), .wb_wr_en(wb_wr_en),
    .branch_taken(branch_taken), .mul_start(mul_start),
    .fwd_sel_a(sa[0]), .fwd_sel_b(sb[0]),
    .pc_en(pe[0]), .if_id_en(ie[0]),
    .if_id_flush(fl[0]), .id_ex_bubble(bu[0]),
    .ex_hold(ho[0]), .perf_stall_cnt(pc[0])
  );

  pipeline_hazard_controller #(.MUL_CYCLES(MULC), .FLUSH_CYCLES(2)) dut1 (
    .clk(clk), .rst(rst),
    .id_rn(id_rn), .id_rm(id_rm),
    .id_rn_used(id_rn_used), .id_rm_used(id_rm_used),
    .ex_rd(ex_rd), .ex_wr_en(ex_wr_en), .ex_is_load(ex_is_load),
    .mem_rd(mem_rd), .mem_wr_en(mem_wr_en),
    .wb_rd(wb_rd), .wb_wr_en(wb_wr_en),
    .branch_taken(branch_taken), .mul_start(mul_start),
    .fwd_sel_a(sa[1]), .fwd_sel_b(sb[1]),
    .pc_en(pe[1]), .if_id_en(ie[1]),
    .if_id_flush(fl[1]), .id_ex_bubble(bu[1]),
    .ex_hold(ho[1]), .perf_stall_cnt(pc[1])
  );

  task automatic chk(input string tag, input int k,
                     input logic [15:0] obs, input logic [15:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s[%0d] observed=%h expected=%h", tag, k, obs, exp);
    end
  endtask

  // Which stage supplies a source: 0 regfile, 1 EX, 2 MEM, 3 WB
  function automatic int src_of(input logic [3:0] s, input logic u);
    int rds [3];
    bit wrs [3];
    rds = '{int'(ex_rd), int'(mem_rd), int'(wb_rd)};
    wrs = '{ex_wr_en, mem_wr_en, wb_wr_en};
    if (!u || s == 4'd15) return 0;
    for (int i = 0; i < 3; i++)
      if (wrs[i] && rds[i] == int'(s))
        return (i == 0 && ex_is_load) ? 0 : i + 1;
    return 0;
  endfunction

  function automatic bit ld_hit(input logic [3:0] s, input logic u);
    return u && s != 4'd15 && ex_wr_en && ex_is_load && ex_rd == s;
  endfunction

  // One cycle: compare both DUTs with the model, then advance
  task automatic tick();
    int ea, eb, ep, ei, ef, eh, eu, nb, nf, fcy;
    bit lu;
    @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      fcy = k + 1;
      ea = src_of(id_rn, id_rn_used);
      eb = src_of(id_rm, id_rm_used);
      lu = ld_hit(id_rn, id_rn_used) || ld_hit(id_rm, id_rm_used);
      ep = 1; ei = 1; ef = 0; eu = 0; eh = 0;
      nb = busy[k]; nf = flc[k];
      if (rst) begin
        ea = 0; eb = 0; nb = 0; nf = 0;
      end else if (busy[k] > 0) begin
        if (busy[k] > 1) begin ep = 0; ei = 0; eh = 1; end
        nb = busy[k] - 1;
      end else if (flc[k] > 0) begin
        ef = 1; eu = 1; nf = flc[k] - 1;
      end else if (branch_taken) begin
        ef = 1; eu = 1; nf = fcy - 1;
      end else if (mul_start) begin
        ep = 0; ei = 0; eh = 1; nb = MULC - 1;
      end else if (lu) begin
        ep = 0; ei = 0; eu = 1;
      end
      chk("fwd_a", k, 16'(sa[k]), 16'(ea));
      chk("fwd_b", k, 16'(sb[k]), 16'(eb));
      chk("pc_en", k, 16'(pe[k]), 16'(ep));
      chk("if_id_en", k, 16'(ie[k]), 16'(ei));
      chk("flush", k, 16'(fl[k]), 16'(ef));
      chk("bubble", k, 16'(bu[k]), 16'(eu));
      chk("ex_hold", k, 16'(ho[k]), 16'(eh));
      chk("perf", k, pc[k], 16'(perf[k]));
      busy[k] = nb;
      flc[k]  = nf;
      if (rst) perf[k] = 0;
      else if (ep == 0 && perf[k] < 65535) perf[k] = perf[k] + 1;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    id_rn = 4'd0; id_rm = 4'd0;
    id_rn_used = 1'b0; id_rm_used = 1'b0;
    ex_rd = 4'd0; mem_rd = 4'd0; wb_rd = 4'd0;
    ex_wr_en = 1'b0; ex_is_load = 1'b0;
    mem_wr_en = 1'b0; wb_wr_en = 1'b0;
    branch_taken = 1'b0; mul_start = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  initial begin
    for (int k = 0; k < 2; k++) begin
      busy[k] = 0; flc[k] = 0; perf[k] = 0;
    end
    idle();
    rst = 1'b1;
    #1;
    tick();
    tick();
    rst = 1'b0;
    chk("reset_perf", 0, pc[0], 16'h0);
    chk("reset_pc_en", 0, 16'(pe[0]), 16'h1);

    // forwarding: MEM beats WB, PC excluded
    id_rn = 4'd3; id_rn_used = 1'b1;
    ex_rd = 4'd8; mem_rd = 4'd3; wb_rd = 4'd3;
    ex_wr_en = 1'b1; mem_wr_en = 1'b1; wb_wr_en = 1'b1;
    #1;
    chk("mem_over_wb", 0, 16'(sa[0]), 16'h2);
    tick();
    id_rn = 4'd15; ex_rd = 4'd15;
    #1;
    chk("pc_no_fwd", 0, 16'(sa[0]), 16'h0);
    tick();

    // load-use stall, then MEM forward
    idle();
    do_reset();
    id_rm = 4'd3; id_rm_used = 1'b1;
    ex_rd = 4'd3; ex_wr_en = 1'b1; ex_is_load = 1'b1;
    #1;
    chk("lu_pc_en", 0, 16'(pe[0]), 16'h0);
    chk("lu_bubble", 0, 16'(bu[0]), 16'h1);
    tick();
    ex_wr_en = 1'b0; ex_is_load = 1'b0;
    mem_rd = 4'd3; mem_wr_en = 1'b1;
    #1;
    chk("lu_fwd_mem", 0, 16'(sb[0]), 16'h2);
    chk("lu_perf", 0, pc[0], 16'h1);
    tick();

    // multiply hold with a branch mid-hold
    idle();
    do_reset();
    mul_start = 1'b1;
    tick();
    mul_start = 1'b0;
    branch_taken = 1'b1;
    #1;
    chk("mul_hold2", 0, 16'(ho[0]), 16'h1);
    chk("mul_no_flush", 0, 16'(fl[0]), 16'h0);
    tick();
    branch_taken = 1'b0;
    tick();
    #1;
    chk("mul_release", 0, 16'(ho[0]), 16'h0);
    chk("mul_perf", 0, pc[0], 16'h3);
    tick();

    // branch priority over mul and load-use
    idle();
    id_rn = 4'd5; id_rn_used = 1'b1;
    ex_rd = 4'd5; ex_wr_en = 1'b1; ex_is_load = 1'b1;
    branch_taken = 1'b1; mul_start = 1'b1;
    #1;
    chk("br_pc_en", 0, 16'(pe[0]), 16'h1);
    chk("br_flush", 1, 16'(fl[1]), 16'h1);
    tick();
    idle();
    #1;
    chk("br_flush2", 1, 16'(fl[1]), 16'h1);
    chk("br_flush2_off", 0, 16'(fl[0]), 16'h0);
    tick();
    tick();

    // reset on hold cycle 2
    mul_start = 1'b1;
    tick();
    mul_start = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
    chk("rst_mul_hold", 0, 16'(ho[0]), 16'h0);
    chk("rst_mul_perf", 0, pc[0], 16'h0);
    tick();

    // random traffic
    for (int n = 0; n < 3000; n++) begin
      id_rn = ($urandom % 6 == 0) ? 4'd15 : 4'($urandom % 4);
      id_rm = ($urandom % 6 == 0) ? 4'd15 : 4'($urandom % 4);
      ex_rd  = 4'($urandom % 4);
      mem_rd = 4'($urandom % 4);
      wb_rd  = 4'($urandom % 4);
      id_rn_used = 1'($urandom);
      id_rm_used = 1'($urandom);
      ex_wr_en   = 1'($urandom);
      mem_wr_en  = 1'($urandom);
      wb_wr_en   = 1'($urandom);
      ex_is_load = ($urandom % 3 == 0);
      branch_taken = ($urandom % 10 == 0);
      mul_start    = ($urandom % 12 == 0);
      rst          = ($urandom % 80 == 0);
      tick();
    end

    // saturation: continuous load-use stall
    idle();
    do_reset();
    id_rn = 4'd3; id_rn_used = 1'b1;
    ex_rd = 4'd3; ex_wr_en = 1'b1; ex_is_load = 1'b1;
    for (int n = 0; n < 65537; n++) tick();
    chk("sat_max", 0, pc[0], 16'hFFFF);
    chk("sat_max", 1, pc[1], 16'hFFFF);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
